// File: rtl/ebi_master.sv
// ebi_master: EBI bus initiator; turns single read/write requests and 80-bit
// command pushes into timed cs/rd/wr/addr/data cycles.
// Latency: bus cycle starts the cycle after acceptance; read data pulses out
// the cycle after the last strobe cycle. Backpressure: req_ready/cmd_ready are
// high only in IDLE (and not during rst); a pending command wins over a request.
// Ports: clk/rst (sync, active-high); req_* single transaction handshake;
// cmd_* 80-bit command push (five writes to addr 1..5); rsp_valid/rsp_rdata
// read return; ebi_* registered bus pins; ebi_din bus read data; busy = not IDLE.
module ebi_master #(
    parameter int ADDR_W     = 19,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [79:0]       cmd_data,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              ebi_cs,
    output logic              ebi_rd,
    output logic              ebi_wr,
    output logic [ADDR_W-1:0] ebi_addr,
    output logic [15:0]       ebi_dout,
    output logic              ebi_doe,
    input  logic [15:0]       ebi_din,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

    // Counter reload values: a phase of N cycles loads N-1 and ends at 0.
    localparam logic [7:0] SETUP_LD  = 8'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
    localparam logic [7:0] STROBE_LD = 8'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [7:0] HOLD_LD   = 8'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);
    localparam logic [7:0] GAP_LD    = 8'((GAP_CYC    > 0) ? GAP_CYC    - 1 : 0);

    // A zero-length setup phase starts each word directly in STROBE.
    localparam state_t     FIRST    = (SETUP_CYC != 0) ? SETUP : STROBE;
    localparam logic [7:0] FIRST_LD = (SETUP_CYC != 0) ? SETUP_LD : STROBE_LD;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_load_val;
    logic        cnt_load;
    logic        acc_cmd, acc_req, next_word, dir_nxt, active_nxt, last_strobe;
    logic [2:0]  word;
    logic        write_q, cmd_mode;
    logic [79:0] cmd_buf;

    assign cmd_ready   = (state == IDLE) && !rst;
    assign req_ready   = cmd_ready && !cmd_valid;
    assign busy        = (state != IDLE);
    assign acc_cmd     = cmd_ready && cmd_valid;
    assign acc_req     = req_ready && req_valid;
    assign last_strobe = (state == STROBE) && (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = 8'd0;
        next_word    = 1'b0;
        case (state)
            IDLE: begin
                if (acc_cmd || acc_req) begin
                    state_nxt    = FIRST;
                    cnt_load     = 1'b1;
                    cnt_load_val = FIRST_LD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt    = STROBE;
                    cnt_load     = 1'b1;
                    cnt_load_val = STROBE_LD;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    cnt_load = 1'b1;
                    if (HOLD_CYC != 0) begin
                        state_nxt    = HOLD;
                        cnt_load_val = HOLD_LD;
                    end else begin
                        state_nxt    = GAP;
                        cnt_load_val = GAP_LD;
                    end
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt    = GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LD;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    // Command words run back-to-back without returning to IDLE.
                    if (cmd_mode && (word != 3'd4)) begin
                        state_nxt    = FIRST;
                        cnt_load     = 1'b1;
                        cnt_load_val = FIRST_LD;
                        next_word    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Direction of the transaction the bus will be in next cycle.
    assign dir_nxt    = acc_cmd ? 1'b1 : (acc_req ? req_write : write_q);
    assign active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 8'd0;
            word      <= 3'd0;
            write_q   <= 1'b0;
            cmd_mode  <= 1'b0;
            cmd_buf   <= 80'd0;
            ebi_cs    <= 1'b0;
            ebi_rd    <= 1'b0;
            ebi_wr    <= 1'b0;
            ebi_doe   <= 1'b0;
            ebi_addr  <= '0;
            ebi_dout  <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
        end else begin
            if (cnt_load)           cnt <= cnt_load_val;
            else if (cnt != 8'd0)   cnt <= cnt - 8'd1;

            if (acc_cmd) begin
                cmd_mode <= 1'b1;
                word     <= 3'd0;
                cmd_buf  <= cmd_data << 16;
                ebi_addr <= ADDR_W'(1);
                ebi_dout <= cmd_data[79:64];
            end else if (acc_req) begin
                cmd_mode <= 1'b0;
                ebi_addr <= req_addr;
                if (req_write) ebi_dout <= req_wdata;
            end else if (next_word) begin
                // cmd_buf is pre-shifted so the next word always sits on top.
                word     <= word + 3'd1;
                ebi_addr <= ADDR_W'(word) + ADDR_W'(2);
                ebi_dout <= cmd_buf[79:64];
                cmd_buf  <= cmd_buf << 16;
            end

            write_q   <= dir_nxt;
            ebi_cs    <= active_nxt;
            ebi_rd    <= (state_nxt == STROBE) && !dir_nxt;
            ebi_wr    <= (state_nxt == STROBE) && dir_nxt;
            ebi_doe   <= active_nxt && dir_nxt;
            rsp_valid <= last_strobe && !write_q;
            if (last_strobe && !write_q) rsp_rdata <= ebi_din;
        end
    end

endmodule

// File: tb/tb_ebi_master.sv
// Testbench for ebi_master: default-parameter DUT plus a corner-parameter DUT
// (no setup/hold, 2-cycle strobe), both checked every cycle against a
// transaction-schedule model, with directed literal checks and a random phase.
module tb_ebi_master;

    localparam int P_SC[2] = '{1, 0};
    localparam int P_ST[2] = '{4, 2};
    localparam int P_HC[2] = '{1, 0};
    localparam int P_GC[2] = '{3, 3};

    logic        clk = 1'b0;
    logic        rst[2];
    logic        req_valid[2], req_ready[2], req_write[2];
    logic [18:0] req_addr[2];
    logic [15:0] req_wdata[2];
    logic        cmd_valid[2], cmd_ready[2];
    logic [79:0] cmd_data[2];
    logic        rsp_valid[2];
    logic [15:0] rsp_rdata[2];
    logic        ebi_cs[2], ebi_rd[2], ebi_wr[2], ebi_doe[2], busy[2];
    logic [18:0] ebi_addr[2];
    logic [15:0] ebi_dout[2], ebi_din[2];
    bit          din_hold[2];

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ebi_master u_dut (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .ebi_cs(ebi_cs[0]), .ebi_rd(ebi_rd[0]), .ebi_wr(ebi_wr[0]),
        .ebi_addr(ebi_addr[0]), .ebi_dout(ebi_dout[0]), .ebi_doe(ebi_doe[0]),
        .ebi_din(ebi_din[0]), .busy(busy[0])
    );

    ebi_master #(.SETUP_CYC(0), .STROBE_CYC(2), .HOLD_CYC(0)) u_corner (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .ebi_cs(ebi_cs[1]), .ebi_rd(ebi_rd[1]), .ebi_wr(ebi_wr[1]),
        .ebi_addr(ebi_addr[1]), .ebi_dout(ebi_dout[1]), .ebi_doe(ebi_doe[1]),
        .ebi_din(ebi_din[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: schedule of bus words ----------------
    int          job_start[2], job_end[2], rsp_due[2];
    logic [18:0] job_addr[2][5];
    logic [15:0] job_data[2][5];
    bit          job_wr[2][5];
    logic [18:0] last_addr[2];
    logic [15:0] exp_rdata[2];
    bit          live[2], was_rst[2];

    always @(negedge clk) begin : model
        int   k, o, P, c, sc, st, hc;
        bit   in_job, wr_k, e_cs, e_st, e_rdy;
        logic [18:0] e_addr;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            sc = P_SC[d]; st = P_ST[d]; hc = P_HC[d];
            P  = sc + st + hc + P_GC[d];
            in_job = (c >= job_start[d]) && (c < job_end[d]);
            k = 0; o = 0; wr_k = 1'b0; e_addr = last_addr[d];
            if (in_job) begin
                k = (c - job_start[d]) / P;
                o = (c - job_start[d]) % P;
                wr_k   = job_wr[d][k];
                e_addr = job_addr[d][k];
            end
            e_cs  = in_job && (o < sc + st + hc);
            e_st  = in_job && (o >= sc) && (o < sc + st);
            e_rdy = !in_job && !rst[d];
            if (live[d]) begin
                chk("model_cs",        80'(ebi_cs[d]),    80'(e_cs));
                chk("model_rd",        80'(ebi_rd[d]),    80'(e_st && !wr_k));
                chk("model_wr",        80'(ebi_wr[d]),    80'(e_st && wr_k));
                chk("model_doe",       80'(ebi_doe[d]),   80'(e_cs && wr_k));
                chk("model_busy",      80'(busy[d]),      80'(in_job));
                chk("model_addr",      80'(ebi_addr[d]),  80'(e_addr));
                chk("model_cmd_ready", 80'(cmd_ready[d]), 80'(e_rdy));
                chk("model_req_ready", 80'(req_ready[d]), 80'(e_rdy && !cmd_valid[d]));
                chk("model_rsp_valid", 80'(rsp_valid[d]), 80'(c == rsp_due[d]));
                chk("model_rsp_rdata", 80'(rsp_rdata[d]), 80'(exp_rdata[d]));
                if (e_cs && wr_k) chk("model_dout", 80'(ebi_dout[d]), 80'(job_data[d][k]));
                if (was_rst[d])   chk("model_dout_rst", 80'(ebi_dout[d]), 80'(0));
            end
            if (rst[d]) begin
                job_start[d] = 0; job_end[d] = 0; rsp_due[d] = -1;
                last_addr[d] = '0; exp_rdata[d] = '0;
                was_rst[d] = 1'b1; live[d] = 1'b1;
            end else begin
                was_rst[d] = 1'b0;
                if (e_st && !wr_k && (o == sc + st - 1)) begin
                    exp_rdata[d] = ebi_din[d];
                    rsp_due[d]   = c + 1;
                end
                if (e_rdy && cmd_valid[d]) begin
                    for (int w = 0; w < 5; w++) begin
                        job_addr[d][w] = 19'(w + 1);
                        job_data[d][w] = cmd_data[d][79 - 16*w -: 16];
                        job_wr[d][w]   = 1'b1;
                    end
                    job_start[d] = c + 1; job_end[d] = c + 1 + 5*P;
                    last_addr[d] = 19'd5;
                end else if (e_rdy && req_valid[d]) begin
                    job_addr[d][0] = req_addr[d];
                    job_data[d][0] = req_wdata[d];
                    job_wr[d][0]   = req_write[d];
                    job_start[d] = c + 1; job_end[d] = c + 1 + P;
                    last_addr[d] = req_addr[d];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                if (!din_hold[d]) ebi_din[d] = 16'($urandom);
        end
    end

    task automatic at(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic handshake(input int d, output int t, output logic cr, output logic rr);
        t = -1; cr = 1'b0; rr = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((cmd_valid[d] && cmd_ready[d]) || (req_valid[d] && req_ready[d])) begin
                t = cyc; cr = cmd_ready[d]; rr = req_ready[d];
                break;
            end
        end
        if (t < 0) begin
            nchk++; nerr++;
            $display("FAIL handshake_timeout: dut %0d never accepted, expected acceptance within 200 cycles", d);
            t = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_drive(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst[d]       = ($urandom_range(0, 249) == 0);
            req_valid[d] = ($urandom_range(0, 2) == 0);
            req_write[d] = 1'($urandom);
            req_addr[d]  = 19'($urandom);
            req_wdata[d] = 16'($urandom);
            cmd_valid[d] = (d == 0) && ($urandom_range(0, 5) == 0);
            cmd_data[d]  = {$urandom, $urandom, 16'($urandom)};
        end
        @(posedge clk); #1;
        rst[d] = 1'b0; req_valid[d] = 1'b0; cmd_valid[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int   t;
        logic cr, rr;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; cmd_valid[d] = 1'b0; cmd_data[d] = '0; ebi_din[d] = '0;
            din_hold[d] = 1'b0; job_start[d] = 0; job_end[d] = 0; rsp_due[d] = -1;
            last_addr[d] = '0; exp_rdata[d] = '0; live[d] = 1'b0; was_rst[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 80'(req_ready[0]), 80'(0));
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk("reset_cs",        80'(ebi_cs[0]),    80'(0));
        chk("reset_addr",      80'(ebi_addr[0]),  80'(0));
        chk("reset_rdata",     80'(rsp_rdata[0]), 80'(0));
        chk("reset_req_ready", 80'(req_ready[0]), 80'(1));
        @(posedge clk); #1;

        // 1: single write, addr 7, data DEAD
        req_write[0] = 1'b1; req_addr[0] = 19'd7; req_wdata[0] = 16'hDEAD; req_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        req_valid[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            at(t + i);
            chk("t1_cs",    80'(ebi_cs[0]),    80'(i <= 6));
            chk("t1_wr",    80'(ebi_wr[0]),    80'(i >= 2 && i <= 5));
            chk("t1_doe",   80'(ebi_doe[0]),   80'(i <= 6));
            chk("t1_ready", 80'(req_ready[0]), 80'(i == 10));
            if (i <= 6) chk("t1_dout", 80'(ebi_dout[0]), 80'(16'hDEAD));
        end
        @(posedge clk); #1;

        // 2: read, addr 6, bus returns 1234
        din_hold[0] = 1'b1; ebi_din[0] = 16'h1234;
        req_write[0] = 1'b0; req_addr[0] = 19'd6; req_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        req_valid[0] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            at(t + i);
            chk("t2_rd",  80'(ebi_rd[0]),    80'(i >= 2 && i <= 5));
            chk("t2_doe", 80'(ebi_doe[0]),   80'(0));
            chk("t2_rsp", 80'(rsp_valid[0]), 80'(i == 6));
            if (i >= 6) chk("t2_rdata", 80'(rsp_rdata[0]), 80'(16'h1234));
        end
        din_hold[0] = 1'b0;
        at(t + 10);
        @(posedge clk); #1;

        // 3: command push, five writes to addr 1..5
        cmd_data[0] = 80'h0001_0002_0003_0004_0005; cmd_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        cmd_valid[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at(t + 1 + 9*k);
            chk("t3_wr_before", 80'(ebi_wr[0]), 80'(0));
            at(t + 2 + 9*k);
            chk("t3_wr_rise", 80'(ebi_wr[0]),   80'(1));
            chk("t3_addr",    80'(ebi_addr[0]), 80'(k + 1));
            chk("t3_dout",    80'(ebi_dout[0]), 80'(k + 1));
        end
        at(t + 45);
        chk("t3_cmd_ready_busy", 80'(cmd_ready[0]), 80'(0));
        at(t + 46);
        chk("t3_cmd_ready_back", 80'(cmd_ready[0]), 80'(1));
        @(posedge clk); #1;

        // 4: command and request together; command wins
        cmd_data[0] = {$urandom, $urandom, 16'($urandom)}; cmd_valid[0] = 1'b1;
        req_write[0] = 1'b1; req_addr[0] = 19'h12345; req_wdata[0] = 16'hBEEF; req_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        chk("t4_cmd_ready", 80'(cr), 80'(1));
        chk("t4_req_ready", 80'(rr), 80'(0));
        cmd_valid[0] = 1'b0;
        at(t + 45);
        chk("t4_req_wait", 80'(req_ready[0]), 80'(0));
        at(t + 46);
        chk("t4_req_acc", 80'(req_ready[0]), 80'(1));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        at(t + 47);
        chk("t4_setup_cs", 80'(ebi_cs[0]), 80'(1));
        chk("t4_setup_wr", 80'(ebi_wr[0]), 80'(0));
        at(t + 48);
        chk("t4_wr",   80'(ebi_wr[0]),   80'(1));
        chk("t4_addr", 80'(ebi_addr[0]), 80'(19'h12345));
        chk("t4_dout", 80'(ebi_dout[0]), 80'(16'hBEEF));
        at(t + 56);
        @(posedge clk); #1;

        // 5: reset on the 2nd strobe cycle of command word 3
        cmd_data[0] = 80'hAAAA_BBBB_CCCC_DDDD_EEEE; cmd_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        cmd_valid[0] = 1'b0;
        at(t + 20);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        at(t + 21);
        chk("t5_mid_wr",   80'(ebi_wr[0]),   80'(1));
        chk("t5_mid_addr", 80'(ebi_addr[0]), 80'(3));
        @(posedge clk); #1;
        rst[0] = 1'b0;
        at(t + 22);
        chk("t5_cs",   80'(ebi_cs[0]),  80'(0));
        chk("t5_rd",   80'(ebi_rd[0]),  80'(0));
        chk("t5_wr",   80'(ebi_wr[0]),  80'(0));
        chk("t5_doe",  80'(ebi_doe[0]), 80'(0));
        chk("t5_busy", 80'(busy[0]),    80'(0));
        @(posedge clk); #1;
        din_hold[0] = 1'b1; ebi_din[0] = 16'h5A5A;
        req_write[0] = 1'b0; req_addr[0] = 19'd3; req_valid[0] = 1'b1;
        handshake(0, t, cr, rr);
        req_valid[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            at(t + i);
            chk("t5_no_wr", 80'(ebi_wr[0]),    80'(0));
            chk("t5_rsp",   80'(rsp_valid[0]), 80'(i == 6));
        end
        chk("t5_rdata", 80'(rsp_rdata[0]), 80'(16'h5A5A));
        din_hold[0] = 1'b0;

        // 6: corner parameters, read on the second instance
        din_hold[1] = 1'b1; ebi_din[1] = 16'hC3C3;
        req_write[1] = 1'b0; req_addr[1] = 19'h00042; req_valid[1] = 1'b1;
        handshake(1, t, cr, rr);
        req_valid[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            at(t + i);
            chk("t6_cs",    80'(ebi_cs[1]),    80'(i <= 2));
            chk("t6_rd",    80'(ebi_rd[1]),    80'(i <= 2));
            chk("t6_rsp",   80'(rsp_valid[1]), 80'(i == 3));
            chk("t6_ready", 80'(req_ready[1]), 80'(i == 6));
        end
        chk("t6_rdata", 80'(rsp_rdata[1]), 80'(16'hC3C3));
        din_hold[1] = 1'b0;

        // random phase on both instances, checked by the model
        fork
            rand_drive(0, 1500);
            rand_drive(1, 1500);
        join
        repeat (60) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
